// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the register-file parity scrubber and its error log.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        ERR_SRC_SCRUB = 2'd0,
        ERR_SRC_A     = 2'd1,
        ERR_SRC_B     = 2'd2,
        ERR_SRC_C     = 2'd3
    } rf_err_src_e;

    typedef enum logic [1:0] {
        SCRUB_IDLE   = 2'd0,
        SCRUB_WAIT   = 2'd1,
        SCRUB_ACTIVE = 2'd2
    } rf_scrub_state_e;

    localparam int RF_SCRUB_FIRST = 1;
    localparam int RF_INT_LAST    = 31;
    localparam int RF_FP_LAST     = 63;

endpackage

// File: rtl/cv32e40p_rf_err_log.sv
// Parity error log: first-error capture with fixed source priority, saturating count, one-cycle alarm.
module cv32e40p_rf_err_log
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  err_a,
    input  logic                  err_b,
    input  logic                  err_c,
    input  logic                  err_s,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_c,
    input  logic [ADDR_WIDTH-1:0] addr_s,
    output logic                  alarm,
    output logic                  err_valid,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [1:0]            err_src,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    logic                  any_err;
    logic [ADDR_WIDTH-1:0] cap_addr;
    rf_err_src_e           cap_src;

    assign any_err = err_a | err_b | err_c | err_s;

    always_comb begin
        cap_addr = addr_s;
        cap_src  = ERR_SRC_SCRUB;
        if (err_a) begin
            cap_addr = addr_a;
            cap_src  = ERR_SRC_A;
        end else if (err_b) begin
            cap_addr = addr_b;
            cap_src  = ERR_SRC_B;
        end else if (err_c) begin
            cap_addr = addr_c;
            cap_src  = ERR_SRC_C;
        end
    end

    // A clear coinciding with a new error restarts the log with that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm     <= 1'b0;
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_src   <= '0;
            err_cnt   <= '0;
        end else begin
            alarm <= any_err;
            if (clear) begin
                err_valid <= any_err;
                err_addr  <= any_err ? cap_addr : '0;
                err_src   <= any_err ? cap_src : '0;
                err_cnt   <= any_err ? CNT_WIDTH'(1) : '0;
            end else if (any_err) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    err_addr  <= cap_addr;
                    err_src   <= cap_src;
                end
            end
        end
    end

endmodule

// File: rtl/cv32e40p_rf_scrub_ctrl.sv
// Background register-file parity scrubber on idle port-C cycles, plus port A/B/C parity monitor.
// state        | meaning
// SCRUB_IDLE   | scrubbing disabled, pointer parked at first register
// SCRUB_WAIT   | counting idle cycles until the next scrub read
// SCRUB_ACTIVE | scrub read pending; issued on the first cycle the core leaves port C free
module cv32e40p_rf_scrub_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int FPU            = 0,
    parameter int ZFINX          = 0,
    parameter int SCRUB_INTERVAL = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scrub_en_i,
    input  logic                     clear_i,
    input  logic [ADDR_WIDTH-1:0]    core_raddr_c_i,
    input  logic                     core_rd_c_req_i,
    input  logic                     core_rd_a_req_i,
    input  logic                     core_rd_b_req_i,
    input  logic [ADDR_WIDTH-1:0]    core_raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]    core_raddr_b_i,
    output logic [ADDR_WIDTH-1:0]    rf_raddr_c_o,
    input  logic [2:0]               rf_par_ok_i,
    output logic                     scrub_busy_o,
    output logic                     sweep_done_o,
    output logic                     alarm_o,
    output logic                     err_valid_o,
    output logic [ADDR_WIDTH-1:0]    err_addr_o,
    output logic [1:0]               err_src_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int LAST = (FPU != 0 && ZFINX == 0) ? RF_FP_LAST : RF_INT_LAST;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(RF_SCRUB_FIRST);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST);
    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCRUB_INTERVAL - 1);

    rf_scrub_state_e       state, state_next;
    logic [ADDR_WIDTH-1:0] ptr, ptr_next;
    logic [CNT_W-1:0]      cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCRUB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= FIRST_ADDR;
            cnt <= '0;
        end else begin
            ptr <= ptr_next;
            cnt <= cnt_next;
        end
    end

    // Disabling scrubbing wins over everything; a grant in that same cycle is still checked.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        if (!scrub_en_i) begin
            state_next = SCRUB_IDLE;
            ptr_next   = FIRST_ADDR;
        end else begin
            case (state)
                SCRUB_IDLE: begin
                    state_next = SCRUB_WAIT;
                    cnt_next   = RELOAD;
                end
                SCRUB_WAIT: begin
                    if (cnt == '0) begin
                        state_next = SCRUB_ACTIVE;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                SCRUB_ACTIVE: begin
                    if (!core_rd_c_req_i) begin
                        state_next = SCRUB_WAIT;
                        cnt_next   = RELOAD;
                        ptr_next   = (ptr == LAST_ADDR) ? FIRST_ADDR : ptr + 1'b1;
                    end
                end
                default: state_next = SCRUB_IDLE;
            endcase
        end
    end

    always_comb begin
        scrub_busy_o = (state == SCRUB_ACTIVE) && !core_rd_c_req_i;
        rf_raddr_c_o = scrub_busy_o ? ptr : core_raddr_c_i;
        sweep_done_o = scrub_busy_o && (ptr == LAST_ADDR);
    end

    logic err_a, err_b, err_c, err_s;

    assign err_a = core_rd_a_req_i & ~rf_par_ok_i[0];
    assign err_b = core_rd_b_req_i & ~rf_par_ok_i[1];
    assign err_c = core_rd_c_req_i & ~rf_par_ok_i[2];
    assign err_s = scrub_busy_o    & ~rf_par_ok_i[2];

    cv32e40p_rf_err_log #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_err_log (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_i),
        .err_a    (err_a),
        .err_b    (err_b),
        .err_c    (err_c),
        .err_s    (err_s),
        .addr_a   (core_raddr_a_i),
        .addr_b   (core_raddr_b_i),
        .addr_c   (core_raddr_c_i),
        .addr_s   (ptr),
        .alarm    (alarm_o),
        .err_valid(err_valid_o),
        .err_addr (err_addr_o),
        .err_src  (err_src_o),
        .err_cnt  (err_cnt_o)
    );

endmodule
